// File: rtl/quantum_scheduler.sv
// Preemptive round-robin scheduler: counts retired instructions against a quantum
// and sequences save / select / load context switches between active program slots.
module quantum_scheduler #(
  parameter  int NPROG       = 4,
  parameter  int QW          = 16,
  parameter  int DEF_QUANTUM = 100,
  localparam int PW          = $clog2(NPROG)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          instr_done,
  input  logic          end_program,
  input  logic          next_program,
  input  logic          defquantum,
  input  logic [QW-1:0] quantum_in,
  input  logic          act_valid,
  input  logic [PW-1:0] act_id,
  input  logic          save_done,
  input  logic          load_done,
  output logic          spc,
  output logic          lpc,
  output logic          stall,
  output logic          change_program,
  output logic [PW-1:0] cur_prog,
  output logic          all_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    SAVE   = 3'd2,
    SELECT = 3'd3,
    LOAD   = 3'd4
  } state_t;

  state_t             state;
  logic [NPROG-1:0]   active;
  logic [NPROG-1:0]   active_nxt;
  logic [PW-1:0]      start;
  logic [QW-1:0]      counter;
  logic [QW-1:0]      quantum;
  logic [QW:0]        cnt_plus1;
  logic               expire;
  logic               found;
  logic [PW-1:0]      winner;
  logic [PW-1:0]      scan_idx;

  // Compare in QW+1 bits so a quantum lowered below the running count still expires.
  assign cnt_plus1 = {1'b0, counter} + {{QW{1'b0}}, 1'b1};
  assign expire    = instr_done && (cnt_plus1 >= {1'b0, quantum});

  // Cyclic first-set-bit search from start; walking down lets the nearest slot win.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    found    = 1'b0;
    winner   = cur_prog;
    scan_idx = start;
    for (int i = NPROG - 1; i >= 0; i--) begin
      scan_idx = start + PW'(i);
      if (active[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  // Activation is applied after termination so a same-edge set wins over the clear.
  always_comb begin
    active_nxt = active;
    if (state == RUN && end_program) active_nxt[cur_prog] = 1'b0;
    if (act_valid)                   active_nxt[act_id]   = 1'b1;
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!reset_n) begin
      state    <= IDLE;
      active   <= '0;
      cur_prog <= '0;
      start    <= '0;
      counter  <= '0;
      quantum  <= QW'(DEF_QUANTUM);
    end else begin
      active <= active_nxt;
      if (defquantum && quantum_in != '0) quantum <= quantum_in;

      case (state)
        IDLE: begin
          if (active != '0) begin
            state <= SELECT;
            start <= cur_prog;
          end
        end
        RUN: begin
          if (instr_done) counter <= counter + QW'(1);
          if (end_program) begin
            state <= SELECT;
            start <= cur_prog + PW'(1);
          end else if (next_program || expire) begin
            state <= SAVE;
          end
        end
        SAVE: begin
          if (save_done) begin
            state <= SELECT;
            start <= cur_prog + PW'(1);
          end
        end
        SELECT: begin
          if (found) begin
            cur_prog <= winner;
            state    <= LOAD;
          end else begin
            state <= IDLE;
          end
        end
        LOAD: begin
          if (load_done) begin
            counter <= '0;
            state   <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stall          = (state != RUN);
  assign spc            = (state == SAVE);
  assign lpc            = (state == LOAD);
  assign change_program = (state == SELECT) && found && (winner != cur_prog);
  assign all_done       = (state == SELECT) && !found;

endmodule

// File: tb/tb_quantum_scheduler.sv
// Directed bench for quantum_scheduler: quantum expiry, yield, termination,
// quantum reload and reset-during-handshake scenarios with hand-derived expectations.
module tb_quantum_scheduler;

  logic        clock;
  logic        reset_n;
  logic        instr_done;
  logic        end_program;
  logic        next_program;
  logic        defquantum;
  logic [15:0] quantum_in;
  logic        act_valid;
  logic [1:0]  act_id;
  logic        save_done;
  logic        load_done;
  logic        spc;
  logic        lpc;
  logic        stall;
  logic        change_program;
  logic [1:0]  cur_prog;
  logic        all_done;

  int n_checks  = 0;
  int n_errors  = 0;
  int n_spc     = 0;
  int n_change  = 0;
  int n_overlap = 0;

  quantum_scheduler #(
    .NPROG      (4),
    .QW         (16),
    .DEF_QUANTUM(100)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .instr_done    (instr_done),
    .end_program   (end_program),
    .next_program  (next_program),
    .defquantum    (defquantum),
    .quantum_in    (quantum_in),
    .act_valid     (act_valid),
    .act_id        (act_id),
    .save_done     (save_done),
    .load_done     (load_done),
    .spc           (spc),
    .lpc           (lpc),
    .stall         (stall),
    .change_program(change_program),
    .cur_prog      (cur_prog),
    .all_done      (all_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) if (spc && lpc) n_overlap++;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
    if (spc) n_spc++;
    if (change_program) n_change++;
  endtask

  initial begin
    reset_n = 0; instr_done = 0; end_program = 0; next_program = 0;
    defquantum = 0; quantum_in = '0; act_valid = 0; act_id = '0;
    save_done = 1; load_done = 1;
    tick(); tick();
    check("rst_stall", 32'(stall), 1);
    check("rst_spc", 32'(spc), 0);
    check("rst_lpc", 32'(lpc), 0);
    check("rst_cur", 32'(cur_prog), 0);
    check("rst_chg", 32'(change_program), 0);
    check("rst_done", 32'(all_done), 0);
    reset_n = 1;

    // 1: slots 0 and 2, quantum 3, immediate acks
    n_change = 0;
    defquantum = 1; quantum_in = 16'd3; act_valid = 1; act_id = 2'd0;
    tick();
    defquantum = 0; act_id = 2'd2;
    tick();                                   // IDLE -> SELECT
    act_valid = 0;
    check("t1_sel_chg", 32'(change_program), 0);
    check("t1_sel_done", 32'(all_done), 0);
    tick();                                   // LOAD
    check("t1_lpc", 32'(lpc), 1);
    check("t1_cur0", 32'(cur_prog), 0);
    tick();                                   // RUN
    check("t1_run", 32'(stall), 0);
    instr_done = 1;
    tick(); tick();
    check("t1_run_2instr", 32'(stall), 0);
    tick();                                   // expiry -> SAVE
    instr_done = 0;
    check("t1_spc", 32'(spc), 1);
    tick();                                   // SELECT
    check("t1_chg_pulse", 32'(change_program), 1);
    tick();                                   // LOAD
    check("t1_cur2", 32'(cur_prog), 2);
    check("t1_chg_off", 32'(change_program), 0);
    tick();                                   // RUN
    check("t1_run2", 32'(stall), 0);
    check("t1_nchg1", 32'(n_change), 1);
    instr_done = 1;
    tick(); tick(); tick();                   // SAVE
    instr_done = 0;
    check("t1_spc2", 32'(spc), 1);
    tick(); tick(); tick();                   // SELECT, LOAD, RUN
    check("t1_back0", 32'(cur_prog), 0);
    check("t1_nchg2", 32'(n_change), 2);
    check("t1_run3", 32'(stall), 0);

    // 2: single active slot 1, quantum 2
    reset_n = 0; tick(); reset_n = 1;
    defquantum = 1; quantum_in = 16'd2; act_valid = 1; act_id = 2'd1;
    tick();
    defquantum = 0; act_valid = 0;
    tick(); tick(); tick();                   // SELECT, LOAD, RUN
    check("t2_cur1", 32'(cur_prog), 1);
    check("t2_run", 32'(stall), 0);
    n_change = 0;
    instr_done = 1;
    tick(); tick();                           // expiry -> SAVE
    instr_done = 0;
    check("t2_spc", 32'(spc), 1);
    tick();                                   // SELECT
    check("t2_sel_spc", 32'(spc), 0);
    tick();                                   // LOAD
    check("t2_lpc", 32'(lpc), 1);
    tick();                                   // RUN
    check("t2_cur_stays", 32'(cur_prog), 1);
    check("t2_no_chg", 32'(n_change), 0);
    instr_done = 1;
    tick();
    check("t2_cnt_cleared", 32'(stall), 0);
    tick();
    instr_done = 0;
    check("t2_expire_again", 32'(spc), 1);
    tick(); tick(); tick();                   // SELECT, LOAD, RUN

    // 3: end_program on the last active slot
    n_spc = 0;
    end_program = 1;
    tick();                                   // SELECT, mask empty
    end_program = 0;
    check("t3_all_done", 32'(all_done), 1);
    check("t3_stall", 32'(stall), 1);
    tick();                                   // IDLE
    check("t3_done_off", 32'(all_done), 0);
    tick();
    check("t3_idle_stall", 32'(stall), 1);
    check("t3_idle_lpc", 32'(lpc), 0);
    check("t3_no_spc", 32'(n_spc), 0);
    act_valid = 1; act_id = 2'd3;
    tick();
    act_valid = 0;
    tick();                                   // SELECT
    tick();                                   // LOAD
    check("t3_lpc", 32'(lpc), 1);
    check("t3_cur3", 32'(cur_prog), 3);
    tick();                                   // RUN

    // 4: yield and expiry together, save_done delayed 5 cycles
    save_done = 0;
    instr_done = 1;
    tick();
    next_program = 1;
    n_spc = 0;
    tick();                                   // SAVE cycle 1
    instr_done = 0; next_program = 0;
    check("t4_stall_a", 32'(stall), 1);
    tick(); tick(); tick();
    check("t4_stall_b", 32'(stall), 1);
    tick(); tick();                           // SAVE cycle 6
    check("t4_still_spc", 32'(spc), 1);
    save_done = 1;
    tick();                                   // SELECT
    check("t4_spc_cycles", 32'(n_spc), 6);
    check("t4_sel_spc", 32'(spc), 0);
    check("t4_sel_stall", 32'(stall), 1);
    tick();                                   // LOAD
    check("t4_lpc", 32'(lpc), 1);
    tick();                                   // RUN
    check("t4_run", 32'(stall), 0);

    // 5: defquantum with zero ignored, then lowered below the count
    defquantum = 1; quantum_in = 16'd0;
    tick();
    defquantum = 0;
    instr_done = 1;
    tick();
    check("t5_q_kept_a", 32'(stall), 0);
    tick();
    instr_done = 0;
    check("t5_q_kept_b", 32'(spc), 1);
    tick(); tick(); tick();                   // SELECT, LOAD, RUN
    defquantum = 1; quantum_in = 16'd5;
    tick();
    defquantum = 0;
    instr_done = 1;
    tick(); tick(); tick();                   // counter = 3
    instr_done = 0;
    check("t5_q5_run", 32'(stall), 0);
    defquantum = 1; quantum_in = 16'd2;
    tick();
    defquantum = 0;
    check("t5_no_instr", 32'(stall), 0);
    instr_done = 1;
    tick();
    instr_done = 0;
    check("t5_lowered_expire", 32'(spc), 1);

    // 6: reset during LOAD
    load_done = 0;
    tick();                                   // SELECT
    tick();                                   // LOAD
    tick();                                   // LOAD held
    check("t6_lpc_held", 32'(lpc), 1);
    reset_n = 0;
    tick();
    reset_n = 1; load_done = 1;
    check("t6_lpc_abandon", 32'(lpc), 0);
    check("t6_stall", 32'(stall), 1);
    check("t6_cur0", 32'(cur_prog), 0);
    tick(); tick();
    check("t6_mask_empty_lpc", 32'(lpc), 0);
    check("t6_mask_empty_chg", 32'(change_program), 0);

    // act_valid and end_program on the same running slot: set wins
    act_valid = 1; act_id = 2'd0;
    tick();
    act_valid = 0;
    tick(); tick(); tick();                   // SELECT, LOAD, RUN
    check("t6_run0", 32'(stall), 0);
    end_program = 1; act_valid = 1; act_id = 2'd0;
    tick();                                   // SELECT, mask still {0}
    end_program = 0; act_valid = 0;
    check("t6_set_wins", 32'(all_done), 0);
    tick();
    check("t6_reload_lpc", 32'(lpc), 1);
    check("t6_reload_cur", 32'(cur_prog), 0);
    tick();
    check("t6_reload_run", 32'(stall), 0);

    check("spc_lpc_overlap", 32'(n_overlap), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/quantum_scheduler.md
Name: quantum_scheduler

Overview:
- Preemptive round-robin scheduler for the multiprogrammed processor.
- Counts instructions retired by the running program and enforces a time quantum. Handles program termination and voluntary yields.
- Sequences the context switch: save the outgoing PC/context (spc), select the next active program, load its context (lpc).
- Sits between the control unit (UC) and the program counter / data RAM context area. Holds the PC stalled while a switch is in progress.

Parameters:
- NPROG, 4, number of program slots; power of two, 2..16.
- QW, 16, width of the quantum register and the instruction counter.
- DEF_QUANTUM, 100, quantum loaded at reset; must be nonzero.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  synchronous reset, active-low.
- instr_done  in  1  one-cycle strobe per instruction retired by the running program.
- end_program  in  1  running program executed its end instruction.
- next_program  in  1  running program yields voluntarily.
- defquantum  in  1  load quantum_in into the quantum register.
- quantum_in  in  QW  new quantum value.
- act_valid  in  1  mark slot act_id active (program loaded).
- act_id  in  $clog2(NPROG)  slot to activate.
- save_done  in  1  context save finished; used only in SAVE.
- load_done  in  1  context load finished; used only in LOAD.
- spc  out  1  save-context request, held high in SAVE.
- lpc  out  1  load-context request, held high in LOAD.
- stall  out  1  freeze PC/pipeline; high in every state except RUN.
- change_program  out  1  one-cycle pulse when cur_prog takes a new value.
- cur_prog  out  $clog2(NPROG)  index of the selected/running program.
- all_done  out  1  one-cycle pulse when no active program remains.

Behaviour:
- Reset (reset_n low at an edge):
  - state=IDLE, active mask=0, cur_prog=0, counter=0, quantum=DEF_QUANTUM.
  - spc, lpc, change_program, all_done = 0; stall = 1 (state is IDLE).
  - Reset during SAVE or LOAD abandons the handshake; spc/lpc are low after that edge.
- Activation:
  - act_valid sets active[act_id] in any state.
  - If the same edge clears that bit via end_program, the set wins.
- defquantum:
  - Loads quantum_in if nonzero; quantum_in=0 is ignored.
  - The new value applies to the comparison from the next cycle.
  - The counter is not cleared.
- IDLE:
  - If the active mask is nonzero, go to SELECT with search start = cur_prog (inclusive).
- RUN (stall=0):
  - instr_done increments the counter.
  - Priority order when events coincide:
    1. end_program: clear active[cur_prog], go to SELECT (no save).
    2. next_program: go to SAVE.
    3. Expiry (instr_done while counter == quantum-1): go to SAVE.
  - If quantum is lowered below counter+1, expiry fires on the next instr_done.
  - Lower-priority events in the same cycle are discarded.
- SAVE:
  - spc=1 until save_done is sampled high; next state SELECT.
  - Search start = cur_prog+1 (mod NPROG).
- SELECT (exactly one cycle):
  - Scan the active mask cyclically from the search start; the first set bit wins.
  - After a save, the current program is considered last.
  - If found: cur_prog <= winner, change_program pulses this cycle if winner != old cur_prog, go to LOAD.
  - If the mask is empty: all_done pulses, go to IDLE.
- LOAD:
  - lpc=1 until load_done is sampled high.
  - Then counter <= 0, go to RUN.
- Timing:
  - Minimum switch latency from expiry strobe to first RUN cycle is 4 cycles (SAVE, SELECT, LOAD each with a same-cycle done).
  - spc and lpc are never high together.

Test Plan:
1. Reset, activate slots 0 and 2, quantum=3, ack immediately.
   - Required: runs 0 for 3 instr_done, then SAVE→SELECT→LOAD, cur_prog=2, change_program pulses once.
   - Required: after 3 more instructions, returns to 0.
2. Single active slot 1, quantum expiry.
   - Required: spc then lpc asserted; cur_prog stays 1; change_program stays 0; RUN resumes with counter=0.
3. end_program on the last active slot.
   - Required: no spc; SELECT, all_done pulse, IDLE, stall=1.
   - Then activate slot 3: LOAD with cur_prog=3.
4. next_program and expiry in the same cycle, with save_done delayed 5 cycles.
   - Required: single SAVE; spc high exactly 6 cycles; stall high throughout.
5. defquantum with quantum_in=0 → quantum unchanged.
   - Then defquantum 5→2 while counter=3: the next instr_done triggers SAVE.
6. reset_n low during LOAD.
   - Required: next cycle lpc=0, state IDLE, mask=0, cur_prog=0.
   - Also: act_valid and end_program on the same slot in the same cycle leave it active.
